regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port general-purpose register file for the next-generation MIPS core, replacing the fixed 2-read/1-write file in the ID/WB stages. It adds the following to combinational reads with write bypass:
- configurable read-port count
- a second write port
- a pending-write scoreboard for long-latency results
- a sequenced hardware clear that zeroes every register after reset or on request

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the next rising edge)
- clear_req  in  1  request full-file clear; honoured only when ready==1
- ready  out  1  file initialised and accepting reads/writes
- we0, we1  in  1  write enables; port 1 is the higher priority
- waddr0, waddr1  in  ADDR_W  write addresses
- wdata0, wdata1  in  DATA_W  write data
- set_busy  in  1  mark set_addr as pending (long-latency op issued)
- set_addr  in  ADDR_W  destination to mark pending
- re  in  NRD  per-port read enables
- raddr  in  NRD*ADDR_W  flattened read addresses; port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NRD*DATA_W  flattened read data
- busy_o  out  NRD  per-port "operand not yet written" flags

## Operation
- FSM states:
  - CLEAR: counter cnt sweeps 0..NREGS-1 and writes zero into regs[cnt], one register per cycle. After cnt==NREGS-1, the state goes to RUN and cnt returns to 0.
  - RUN: normal operation. clear_req==1 goes to CLEAR with cnt=0.
- Reset: state=CLEAR, cnt=0, all busy bits 0. Register contents are not reset directly; the clear sweep zeroes them.
- In CLEAR:
  - ready=0.
  - we0/we1, set_busy and clear_req are ignored.
  - rdata=0 and busy_o=0.
  - All busy bits are held at 0.
- Writes (RUN only):
  - regs[waddrN] <= wdataN when weN==1.
  - When ZERO_REG==1, writes to address 0 are dropped.
  - Both ports to the same address: port 1 data is stored.
- Scoreboard (RUN only):
  - A write on either port clears busy[waddr].
  - set_busy sets busy[set_addr].
  - When set and clear hit the same address in the same cycle, set wins.
  - busy[0] is never set when ZERO_REG==1.
- Read port i (combinational), first matching rule applies:
  - not ready, or re[i]==0 → 0
  - raddr==0 with ZERO_REG → 0
  - bypass match on port 1, then port 0 (see Configuration) → wdata
  - otherwise → regs[raddr]
- busy_o[i] = ready & re[i] & busy[raddr[i]]. It is forced to 0 when the read is bypassed from a same-cycle write.

## Timing
- Read latency: 0 cycles (combinational from raddr/re).
- Write latency: 1 cycle; the value is visible in regs from the next edge.
- Clear: ready rises exactly NREGS rising edges after the first edge sampling rst==1, or after the edge that accepted clear_req.
- Reset asserted mid-clear or mid-run: the next edge restarts CLEAR from cnt=0.
- All outputs are 0 while rst==0, and on the first cycle after release.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding as above. busy_o is suppressed when bypassed.
- REGFILE_BYPASS_EN undefined: reads return regs[raddr] only. A same-cycle write is visible to reads on the next cycle. busy_o reflects the scoreboard bit without suppression.

## Structure
- Add to the shared define header:
  - default DATA_W/ADDR_W aligned with RegBus/RegAddrBus
  - FSM encodings RF_CLEAR/RF_RUN
  - RstEna as 1'b0 for this block's polarity
- One sub-module: regfile_rdport. It implements the per-port mux, bypass and busy_o logic, and is instantiated NRD times in a generate loop. The FSM, storage and scoreboard stay in the top.

## Test plan
- rst low for 2 cycles, then high: ready=0 for 32 edges, then 1. Every address reads 0. The writes attempted during CLEAR have no effect.
- RUN:
  - we0 writes r5=0x1234 → next cycle rdata[0]=0x1234.
  - we1 writes r0=0xFFFF → r0 reads 0.
- Same edge, we0 r7=0xA and we1 r7=0xB → r7 reads 0xB. With bypass, the same-cycle read of r7 returns 0xB; without bypass it returns the old value.
- set_busy r9 → busy_o=1 on a read of r9. Then:
  - write r9=0x55 → busy_o=0 with bypass in the same cycle, and from the next cycle in both builds.
  - set_busy and a write to r9 in the same cycle → busy stays 1.
- clear_req with r3=0x77, then assert rst at clear cycle 10 → ready stays 0 and the sweep restarts. Final r3=0, and all busy bits are 0.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default widths
// matching the core's register bus, FSM encodings and reset polarity.
package regfile_mp_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  // Reset is active-low: rst == RstEna means "in reset".
  localparam logic RstEna = 1'b0;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of regfile_mp: zero/disable gating, optional
// same-cycle write forwarding and the "operand pending" flag.
// Optional feature: REGFILE_BYPASS_EN enables write-to-read forwarding.
module regfile_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RegBus,
  parameter int ADDR_W   = RegAddrBus,
  parameter int ZERO_REG = 1,
  parameter int NREGS    = 2**ADDR_W
) (
  input  logic                    ready,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       raddr,
  input  logic [NREGS*DATA_W-1:0] regs_flat,
  input  logic [NREGS-1:0]        busy,
`ifdef REGFILE_BYPASS_EN
  input  logic                    we0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       waddr0,
  input  logic [ADDR_W-1:0]       waddr1,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic [DATA_W-1:0]       wdata1,
`endif
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy_o
);

  logic              byp_s;
  logic [DATA_W-1:0] byp_data_s;

  // Forwarding select (port 1 has priority), then the read-data priority mux.
  always_comb begin
    byp_s      = 1'b0;
    byp_data_s = '0;
    rdata      = '0;
`ifdef REGFILE_BYPASS_EN
    if (we1 && (waddr1 == raddr)) begin
      byp_s      = 1'b1;
      byp_data_s = wdata1;
    end else if (we0 && (waddr0 == raddr)) begin
      byp_s      = 1'b1;
      byp_data_s = wdata0;
    end else begin
      byp_s      = 1'b0;
      byp_data_s = '0;
    end
`endif
    if (!ready || !re) begin
      rdata = '0;
    end else if ((ZERO_REG != 0) && (raddr == '0)) begin
      rdata = '0;
    end else if (byp_s) begin
      rdata = byp_data_s;
    end else begin
      rdata = regs_flat[int'(raddr)*DATA_W +: DATA_W];
    end
    // A forwarded operand is by definition no longer pending.
    busy_o = ready & re & busy[raddr] & ~byp_s;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file with two write ports, a
// pending-write scoreboard and a sequenced hardware clear.
// Optional feature: REGFILE_BYPASS_EN enables write-to-read forwarding.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RegBus,
  parameter int ADDR_W   = RegAddrBus,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  ready,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic                  set_busy,
  input  logic [ADDR_W-1:0]     set_addr,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        busy_o
);

  localparam int NREGS = 2**ADDR_W;

  rf_state_e                state_q, state_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d;
  logic [NREGS-1:0]         busy_q, busy_d;
  logic [DATA_W-1:0]        regs_q [NREGS];
  logic [DATA_W-1:0]        regs_d [NREGS];
  logic [NREGS*DATA_W-1:0]  regs_flat_s;
  logic                     run_s;
  logic                     wr0_ok_s;
  logic                     wr1_ok_s;

  // Outputs must read as idle as soon as reset is driven, not one edge later.
  assign ready = (rst != RstEna) && (state_q == RF_RUN);
  assign run_s = ready;

  // Writes to the hardwired zero register are discarded.
  assign wr0_ok_s = run_s & we0 & ~((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1_ok_s = run_s & we1 & ~((ZERO_REG != 0) && (waddr1 == '0));

  // Clear-sweep sequencer: CLEAR walks cnt over every register, RUN waits for clear_req.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_CLEAR: begin
        if (cnt_q == ADDR_W'(NREGS-1)) begin
          state_d = RF_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RF_RUN: begin
        if (clear_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = RF_RUN;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Next register contents: sweep zeroing, then port 0, with port 1 overriding.
  always_comb begin
    for (int k = 0; k < NREGS; k++) begin
      if ((rst != RstEna) && (state_q == RF_CLEAR) && (cnt_q == ADDR_W'(k))) begin
        regs_d[k] = '0;
      end else if (wr1_ok_s && (waddr1 == ADDR_W'(k))) begin
        regs_d[k] = wdata1;
      end else if (wr0_ok_s && (waddr0 == ADDR_W'(k))) begin
        regs_d[k] = wdata0;
      end else begin
        regs_d[k] = regs_q[k];
      end
    end
  end

  // Scoreboard update: set beats a same-cycle write; cleared whenever not running.
  always_comb begin
    for (int k = 0; k < NREGS; k++) begin
      if (!run_s || clear_req) begin
        busy_d[k] = 1'b0;
      end else if (set_busy && (set_addr == ADDR_W'(k)) &&
                   !((ZERO_REG != 0) && (k == 0))) begin
        busy_d[k] = 1'b1;
      end else if ((we0 && (waddr0 == ADDR_W'(k))) ||
                   (we1 && (waddr1 == ADDR_W'(k)))) begin
        busy_d[k] = 1'b0;
      end else begin
        busy_d[k] = busy_q[k];
      end
    end
  end

  // Flatten storage for the read-port muxes.
  always_comb begin
    regs_flat_s = '0;
    for (int k = 0; k < NREGS; k++) begin
      regs_flat_s[k*DATA_W +: DATA_W] = regs_q[k];
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (rst == RstEna) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage is zeroed by the clear sweep rather than by reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NREGS; k++) begin
      regs_q[k] <= regs_d[k];
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .NREGS    (NREGS)
    ) u_rdport (
      .ready     (ready),
      .re        (re[i]),
      .raddr     (raddr[i*ADDR_W +: ADDR_W]),
      .regs_flat (regs_flat_s),
      .busy      (busy_q),
`ifdef REGFILE_BYPASS_EN
      .we0       (wr0_ok_s | (run_s & we0)),
      .we1       (wr1_ok_s | (run_s & we1)),
      .waddr0    (waddr0),
      .waddr1    (waddr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
`endif
      .rdata     (rdata[i*DATA_W +: DATA_W]),
      .busy_o    (busy_o[i])
    );
  end

endmodule
